// File: rtl/core_pkg.sv
// Shared types for the dispatch -> reservation station -> execute path.
// Operands carry a ready bit; when clear, the low TAG_W bits name the producing ROB entry.
package core_pkg;

    localparam int TAG_W   = 6;
    localparam int DC2RS_W = 114;
    localparam int RS2EX_W = 112;

    typedef struct packed {
        logic        rdy;
        logic [31:0] val;
    } operand_t;

    typedef struct packed {
        logic             valid;
        logic [9:0]       inst;
        logic [TAG_W-1:0] rob_tag;
        operand_t         opr1;
        operand_t         opr2;
        logic [31:0]      offset;
    } rs_entry_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } cdb_t;

endpackage

// File: rtl/rs_operand_wakeup.sv
// Purpose: replace a waiting operand with the CDB result when the broadcast tag matches.
// Latency: combinational. Backpressure: none, the CDB cannot be stalled.
module rs_operand_wakeup
    import core_pkg::*;
(
    input  operand_t opr_i,
    input  cdb_t     cdb_i,
    output operand_t opr_o
);

    always_comb begin
        opr_o = opr_i;
        if (cdb_i.valid && !opr_i.rdy && (opr_i.val[TAG_W-1:0] == cdb_i.tag)) begin
            opr_o.rdy = 1'b1;
            opr_o.val = cdb_i.data;
        end
    end

endmodule

// File: rtl/reservation_station.sv
// Purpose: age-ordered compacting reservation station; RS_INORDER_EN restricts issue to the oldest entry.
// Latency: issue is combinational from registered state; a CDB wakeup can issue the following cycle.
// Backpressure: issue_valid/issue_ready handshake toward execute; rs_full stalls decode.
module reservation_station #(
    parameter int DEPTH = 4,
    parameter int TAG_W = core_pkg::TAG_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         dispatch_valid,
    input  logic [core_pkg::DC2RS_W-1:0] dc2rs,
    output logic                         rs_full,
    output logic [$clog2(DEPTH+1)-1:0]   rs_count,
    input  logic                         cdb_valid,
    input  logic [TAG_W-1:0]             cdb_tag,
    input  logic [31:0]                  cdb_data,
    output logic                         issue_valid,
    input  logic                         issue_ready,
    output logic [core_pkg::RS2EX_W-1:0] rs2ex
);
    import core_pkg::*;

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int IDX_W = $clog2(DEPTH);

    rs_entry_t        entry_q [DEPTH];
    rs_entry_t        entry_d [DEPTH];
    rs_entry_t        woken   [DEPTH];
    rs_entry_t        shifted [DEPTH];
    operand_t         w_opr1  [DEPTH];
    operand_t         w_opr2  [DEPTH];
    rs_entry_t        disp_entry;
    operand_t         d_opr1;
    operand_t         d_opr2;
    cdb_t             cdb;
    logic [DEPTH-1:0] ready;
    logic [IDX_W-1:0] sel;
    logic             any_ready;
    logic             issue_fire;
    logic             disp_fire;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] wr_idx;

    assign cdb = '{valid: cdb_valid, tag: cdb_tag, data: cdb_data};

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        rs_operand_wakeup u_wake1 (.opr_i(entry_q[g].opr1), .cdb_i(cdb), .opr_o(w_opr1[g]));
        rs_operand_wakeup u_wake2 (.opr_i(entry_q[g].opr2), .cdb_i(cdb), .opr_o(w_opr2[g]));

        assign woken[g] = '{valid:   entry_q[g].valid,
                            inst:    entry_q[g].inst,
                            rob_tag: entry_q[g].rob_tag,
                            opr1:    w_opr1[g],
                            opr2:    w_opr2[g],
                            offset:  entry_q[g].offset};

        // Ready looks at registered operands only, so a wakeup never issues in its own cycle.
        assign ready[g] = entry_q[g].valid && entry_q[g].opr1.rdy && entry_q[g].opr2.rdy;

        if (g == DEPTH-1) begin : g_top
            assign shifted[g] = '0;
        end else begin : g_mid
            assign shifted[g] = woken[g+1];
        end
    end

    rs_operand_wakeup u_wake_d1 (.opr_i(dc2rs[97:65]), .cdb_i(cdb), .opr_o(d_opr1));
    rs_operand_wakeup u_wake_d2 (.opr_i(dc2rs[64:32]), .cdb_i(cdb), .opr_o(d_opr2));

    assign disp_entry = '{valid:   1'b1,
                          inst:    dc2rs[113:104],
                          rob_tag: dc2rs[103:98],
                          opr1:    d_opr1,
                          opr2:    d_opr2,
                          offset:  dc2rs[31:0]};

    always_comb begin
        sel       = '0;
        any_ready = 1'b0;
`ifdef RS_INORDER_EN
        any_ready = ready[0];
`else
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (ready[i]) begin
                sel       = IDX_W'(i);
                any_ready = 1'b1;
            end
        end
`endif
    end

    assign rs_full     = (count_q == CNT_W'(DEPTH));
    assign rs_count    = count_q;
    assign issue_valid = any_ready && !flush;
    assign issue_fire  = issue_valid && issue_ready;
    assign disp_fire   = dispatch_valid && !rs_full && !flush;
    assign wr_idx      = issue_fire ? count_q - CNT_W'(1) : count_q;
    assign rs2ex       = {entry_q[sel].inst, entry_q[sel].rob_tag, entry_q[sel].opr1.val,
                          entry_q[sel].opr2.val, entry_q[sel].offset};

    always_comb begin
        count_d = count_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = woken[i];
            if (issue_fire && (IDX_W'(i) >= sel)) begin
                entry_d[i] = shifted[i];
            end
            if (disp_fire && (CNT_W'(i) == wr_idx)) begin
                entry_d[i] = disp_entry;
            end
        end
        if (flush) begin
            count_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_d[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

`ifndef SYNTHESIS
    // Decode should have stalled; the packet is dropped.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(dispatch_valid && rs_full && !flush))
                else $warning("reservation_station: dispatch while full, packet dropped");
        end
    end
`endif

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: expected issue packets are queued by the stimulus
// and checked by an independent monitor whenever the issue handshake completes.
module tb_reservation_station;
    import core_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         dispatch_valid;
    logic [113:0] dc2rs;
    logic         rs_full;
    logic [2:0]   rs_count;
    logic         cdb_valid;
    logic [5:0]   cdb_tag;
    logic [31:0]  cdb_data;
    logic         issue_valid;
    logic         issue_ready;
    logic [111:0] rs2ex;

    logic [111:0] exp_q [$];
    logic [111:0] mon_e;
    int           total = 0;
    int           bad   = 0;

    always #5 clk = ~clk;

    reservation_station #(.DEPTH(4), .TAG_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .dispatch_valid(dispatch_valid), .dc2rs(dc2rs),
        .rs_full(rs_full), .rs_count(rs_count),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .rs2ex(rs2ex)
    );

    function automatic logic [32:0] opv(input logic [31:0] v);
        return {1'b1, v};
    endfunction

    function automatic logic [32:0] opt(input logic [5:0] t);
        return {1'b0, 26'd0, t};
    endfunction

    function automatic logic [113:0] pkt(input logic [9:0] inst, input logic [5:0] tag,
                                         input logic [32:0] o1, input logic [32:0] o2,
                                         input logic [31:0] off);
        return {inst, tag, o1, o2, off};
    endfunction

    function automatic logic [111:0] xp(input logic [9:0] inst, input logic [5:0] tag,
                                        input logic [31:0] v1, input logic [31:0] v2,
                                        input logic [31:0] off);
        return {inst, tag, v1, v2, off};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [113:0] p);
        dispatch_valid = 1'b1;
        dc2rs          = p;
        tick();
        dispatch_valid = 1'b0;
    endtask

    task automatic bcast(input logic [5:0] t, input logic [31:0] d);
        cdb_valid = 1'b1;
        cdb_tag   = t;
        cdb_data  = d;
        tick();
        cdb_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && issue_valid === 1'b1 && issue_ready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL issue_unexpected: got %h want no issue", rs2ex);
            end else begin
                mon_e = exp_q.pop_front();
                if (rs2ex !== mon_e) begin
                    bad++;
                    $display("FAIL issue_pkt: got %h want %h", rs2ex, mon_e);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; dispatch_valid = 1'b0; dc2rs = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; issue_ready = 1'b0;
        #3;
        chk("reset_count", 32'(rs_count), 32'd0);
        chk("reset_full", 32'(rs_full), 32'd0);
        chk("reset_issue_valid", 32'(issue_valid), 32'd0);
        #9 rst_n = 1'b1;
        tick();

        // Basic dispatch and issue
        issue_ready = 1'b1;
        exp_q.push_back(xp(10'h013, 6'd3, 32'd5, 32'd7, 32'd0));
        disp(pkt(10'h013, 6'd3, opv(32'd5), opv(32'd7), 32'd0));
        #1;
        chk("t1_issue_valid", 32'(issue_valid), 32'd1);
        chk("t1_count_1", 32'(rs_count), 32'd1);
        tick(); #1;
        chk("t1_count_0", 32'(rs_count), 32'd0);

        // CDB wakeup, one cycle to issue
        disp(pkt(10'h033, 6'd5, opt(6'd9), opv(32'd1), 32'd4));
        for (int k = 0; k < 3; k++) begin
            #1 chk("t2_hold", 32'(issue_valid), 32'd0);
            tick();
        end
        cdb_valid = 1'b1; cdb_tag = 6'd9; cdb_data = 32'hDEAD;
        exp_q.push_back(xp(10'h033, 6'd5, 32'hDEAD, 32'd1, 32'd4));
        #1 chk("t2_not_same_cycle", 32'(issue_valid), 32'd0);
        tick();
        cdb_valid = 1'b0;
        #1 chk("t2_woken_issue", 32'(issue_valid), 32'd1);
        tick(); #1;
        chk("t2_count", 32'(rs_count), 32'd0);

        // Out-of-order issue with compaction
        issue_ready = 1'b0;
        disp(pkt(10'h101, 6'd10, opt(6'd20), opv(32'hA1), 32'h10));
        disp(pkt(10'h102, 6'd11, opt(6'd21), opv(32'hB1), 32'h11));
        disp(pkt(10'h103, 6'd12, opv(32'hC0), opv(32'hC1), 32'h12));
        disp(pkt(10'h104, 6'd13, opv(32'hD0), opt(6'd23), 32'h13));
        #1;
        chk("t3_full", 32'(rs_full), 32'd1);
        chk("t3_count4", 32'(rs_count), 32'd4);
`ifndef RS_INORDER_EN
        exp_q.push_back(xp(10'h103, 6'd12, 32'hC0, 32'hC1, 32'h12));
        issue_ready = 1'b1;
        #1 chk("t3_ooo_valid", 32'(issue_valid), 32'd1);
        tick();
        issue_ready = 1'b0;
        #1;
        chk("t3_count3", 32'(rs_count), 32'd3);
        chk("t3_not_full", 32'(rs_full), 32'd0);
        exp_q.push_back(xp(10'h104, 6'd13, 32'hD0, 32'h123, 32'h13));
        bcast(6'd23, 32'h123);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        #1 chk("t3_count2", 32'(rs_count), 32'd2);
        bcast(6'd21, 32'h121);
        bcast(6'd20, 32'h120);
        exp_q.push_back(xp(10'h101, 6'd10, 32'h120, 32'hA1, 32'h10));
        exp_q.push_back(xp(10'h102, 6'd11, 32'h121, 32'hB1, 32'h11));
        issue_ready = 1'b1;
        tick(); tick();
        issue_ready = 1'b0;
`else
        issue_ready = 1'b1;
        #1 chk("t3_inorder_blocked", 32'(issue_valid), 32'd0);
        tick();
        #1 chk("t3_inorder_count4", 32'(rs_count), 32'd4);
        exp_q.push_back(xp(10'h101, 6'd10, 32'h120, 32'hA1, 32'h10));
        bcast(6'd20, 32'h120);
        tick();
        exp_q.push_back(xp(10'h102, 6'd11, 32'h121, 32'hB1, 32'h11));
        exp_q.push_back(xp(10'h103, 6'd12, 32'hC0, 32'hC1, 32'h12));
        bcast(6'd21, 32'h121);
        tick(); tick();
        exp_q.push_back(xp(10'h104, 6'd13, 32'hD0, 32'h123, 32'h13));
        bcast(6'd23, 32'h123);
        tick();
        issue_ready = 1'b0;
`endif
        #1 chk("t3_drained", 32'(rs_count), 32'd0);

        // Full with dispatch + issue + CDB together
        disp(pkt(10'h201, 6'd30, opv(32'hE0), opv(32'hE1), 32'h20));
        disp(pkt(10'h202, 6'd31, opt(6'd40), opv(32'hF1), 32'h21));
        disp(pkt(10'h203, 6'd32, opv(32'h60), opt(6'd41), 32'h22));
        disp(pkt(10'h204, 6'd33, opt(6'd42), opv(32'h71), 32'h23));
        #1 chk("t4_full", 32'(rs_full), 32'd1);
        exp_q.push_back(xp(10'h201, 6'd30, 32'hE0, 32'hE1, 32'h20));
        issue_ready = 1'b1;
        cdb_valid = 1'b1; cdb_tag = 6'd40; cdb_data = 32'h140;
        disp(pkt(10'h205, 6'd34, opv(32'd1), opv(32'd2), 32'h24));
        cdb_valid = 1'b0;
        issue_ready = 1'b0;
        #1;
        chk("t4_count_after_drop", 32'(rs_count), 32'd3);
        chk("t4_not_full", 32'(rs_full), 32'd0);
        exp_q.push_back(xp(10'h202, 6'd31, 32'h140, 32'hF1, 32'h21));
        issue_ready = 1'b1;
        disp(pkt(10'h206, 6'd35, opv(32'h33), opv(32'h34), 32'h25));
        issue_ready = 1'b0;
        #1 chk("t4_count_steady", 32'(rs_count), 32'd3);
        bcast(6'd41, 32'h141);
        bcast(6'd42, 32'h142);
        exp_q.push_back(xp(10'h203, 6'd32, 32'h60, 32'h141, 32'h22));
        exp_q.push_back(xp(10'h204, 6'd33, 32'h142, 32'h71, 32'h23));
        exp_q.push_back(xp(10'h206, 6'd35, 32'h33, 32'h34, 32'h25));
        issue_ready = 1'b1;
        tick(); tick(); tick();
        issue_ready = 1'b0;
        #1;
        chk("t4_drained", 32'(rs_count), 32'd0);
        chk("t4_idle", 32'(issue_valid), 32'd0);

        // Same-cycle CDB capture on dispatch
        exp_q.push_back(xp(10'h301, 6'd44, 32'd3, 32'h10, 32'h30));
        cdb_valid = 1'b1; cdb_tag = 6'd4; cdb_data = 32'h10;
        disp(pkt(10'h301, 6'd44, opv(32'd3), opt(6'd4), 32'h30));
        cdb_valid = 1'b0;
        #1 chk("t5_captured_ready", 32'(issue_valid), 32'd1);
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        #1 chk("t5_count", 32'(rs_count), 32'd0);

        // Flush with concurrent dispatch and ready issue
        disp(pkt(10'h401, 6'd50, opv(32'd1), opv(32'd2), 32'h40));
        disp(pkt(10'h402, 6'd51, opv(32'd3), opv(32'd4), 32'h41));
        disp(pkt(10'h403, 6'd52, opv(32'd5), opv(32'd6), 32'h42));
        #1 chk("t6_count3", 32'(rs_count), 32'd3);
        flush = 1'b1;
        issue_ready = 1'b1;
        dispatch_valid = 1'b1;
        dc2rs = pkt(10'h404, 6'd53, opv(32'd7), opv(32'd8), 32'h43);
        #1 chk("t6_flush_masks_issue", 32'(issue_valid), 32'd0);
        tick();
        flush = 1'b0; dispatch_valid = 1'b0; issue_ready = 1'b0;
        #1;
        chk("t6_flush_count", 32'(rs_count), 32'd0);
        chk("t6_flush_issue_valid", 32'(issue_valid), 32'd0);
        chk("t6_flush_full", 32'(rs_full), 32'd0);

        // Asynchronous reset mid-operation
        disp(pkt(10'h501, 6'd60, opv(32'd9), opv(32'd9), 32'h50));
        disp(pkt(10'h502, 6'd61, opv(32'd8), opv(32'd8), 32'h51));
        #1;
        chk("t7_pre_count", 32'(rs_count), 32'd2);
        chk("t7_pre_valid", 32'(issue_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t7_async_count", 32'(rs_count), 32'd0);
        chk("t7_async_valid", 32'(issue_valid), 32'd0);
        #3 rst_n = 1'b1;
        tick(); #1;
        chk("t7_after_count", 32'(rs_count), 32'd0);

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
